// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the iterative divider.
// State enum, op encodings, data width and iteration counter width.
package div_pkg;

  localparam int XLEN  = 32;
  localparam int RW    = XLEN + 1;
  localparam int CNT_W = 5;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
// rem_in/divisor/dvd_bit in; rem_out (next partial remainder), q_bit out.
module div_step
  import div_pkg::*;
(
  input  logic [RW-1:0]   rem_in,
  input  logic [XLEN-1:0] divisor,
  input  logic            dvd_bit,
  output logic [RW-1:0]   rem_out,
  output logic            q_bit
);

  logic [RW:0] shifted;
  logic [RW:0] dvs_ext;

  always_comb begin
    shifted = {rem_in, dvd_bit};
    dvs_ext = {2'b00, divisor};
    q_bit   = shifted >= dvs_ext;
    rem_out = q_bit ? RW'(shifted - dvs_ext)
                    : RW'(shifted);
  end

endmodule

// File: rtl/div_unit.sv
// div_unit: 32-cycle restoring divider (DIV/DIVU/REM/REMU), valid/ready both sides.
// Ports: i_clk, i_rst_n (sync, active-low), i_valid/o_ready request,
//   i_operand_a, i_operand_b, i_div_op, i_flush (abort),
//   o_valid/i_ready result, o_div_data.
// Macro DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow
//   skip CALC and complete on the accept edge.
module div_unit
  import div_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_operand_a,
  input  logic [XLEN-1:0] i_operand_b,
  input  logic [1:0]      i_div_op,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_div_data
);

  state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  dvs_q;
  logic [XLEN-1:0]  res_q;
  logic [RW-1:0]    rem_q;
  logic [1:0]       op_q;
  logic             neg_q_q;
  logic             neg_r_q;
  logic             zero_q;
  logic             ovf_q;

  logic            accept;
  logic            fast_go;
  logic            is_signed;
  logic            sign_a;
  logic            sign_b;
  logic            zero_in;
  logic            ovf_in;
  logic            last;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic [RW-1:0]   rem_nx;
  logic            q_bit;
  logic [XLEN-1:0] q_mag;
  logic [XLEN-1:0] r_mag;
  logic [XLEN-1:0] q_fin;
  logic [XLEN-1:0] r_fin;
  logic [XLEN-1:0] calc_res;
`ifdef DIV_FAST_SPECIAL_EN
  logic            special_in;
  logic [XLEN-1:0] spec_res;
`endif

  // Quotient bits shift in at the bottom of quo_q
  // while dividend bits shift out at the top.
  div_step u_step (
    .rem_in  (rem_q),
    .divisor (dvs_q),
    .dvd_bit (quo_q[XLEN-1]),
    .rem_out (rem_nx),
    .q_bit   (q_bit)
  );

  always_comb begin
    accept    = (state_q == IDLE) && i_valid && !i_flush;
    is_signed = ~i_div_op[0];
    sign_a    = is_signed & i_operand_a[XLEN-1];
    sign_b    = is_signed & i_operand_b[XLEN-1];
    mag_a     = sign_a ? -i_operand_a : i_operand_a;
    mag_b     = sign_b ? -i_operand_b : i_operand_b;
    zero_in   = i_operand_b == '0;
    ovf_in    = is_signed && (i_operand_a == INT_MIN)
                && (i_operand_b == '1);
`ifdef DIV_FAST_SPECIAL_EN
    special_in = zero_in | ovf_in;
    if (i_div_op[1])
      spec_res = zero_in ? i_operand_a : '0;
    else
      spec_res = zero_in ? '1 : INT_MIN;
    fast_go = special_in;
`else
    fast_go = 1'b0;
`endif
    last  = &cnt_q;
    q_mag = {quo_q[XLEN-2:0], q_bit};
    r_mag = rem_nx[XLEN-1:0];
    // A zero divisor leaves the whole dividend magnitude in the
    // remainder, so re-applying the dividend sign restores it.
    if (zero_q)
      q_fin = '1;
    else if (ovf_q)
      q_fin = INT_MIN;
    else
      q_fin = neg_q_q ? -q_mag : q_mag;
    if (ovf_q)
      r_fin = '0;
    else
      r_fin = neg_r_q ? -r_mag : r_mag;
    calc_res = op_q[1] ? r_fin : q_fin;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = fast_go ? DONE : CALC;
      CALC: if (last) state_d = DONE;
      DONE: if (i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (i_flush) state_d = IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      res_q   <= '0;
      op_q    <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (i_flush) begin
      cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= mag_a;
            dvs_q   <= mag_b;
            op_q    <= i_div_op;
            neg_q_q <= sign_a ^ sign_b;
            neg_r_q <= sign_a;
            zero_q  <= zero_in;
            ovf_q   <= ovf_in;
`ifdef DIV_FAST_SPECIAL_EN
            if (special_in) res_q <= spec_res;
`endif
          end
        end
        CALC: begin
          rem_q <= rem_nx;
          quo_q <= q_mag;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last) res_q <= calc_res;
        end
        default: ;
      endcase
    end
  end

  assign o_ready    = state_q == IDLE;
  assign o_valid    = (state_q == DONE) && !i_flush;
  assign o_div_data = res_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit.
// One task per scenario; expected values are hand-computed constants.
module tb_div_unit;

`ifdef DIV_FAST_SPECIAL_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [1:0]  div_op;
  logic        flush;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] data;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  div_unit dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_operand_a (op_a),
    .i_operand_b (op_b),
    .i_div_op    (div_op),
    .i_flush     (flush),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_div_data  (data)
  );

  // Present one request for one edge, then scramble the operand
  // lines so a design that re-samples them would be caught.
  task automatic issue(input logic [1:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    i_valid = 1'b1;
    div_op  = op;
    op_a    = a;
    op_b    = b;
    @(posedge clk); #1;
    i_valid = 1'b0;
    div_op  = ~op;
    op_a    = 32'hDEAD_BEEF;
    op_b    = 32'h0000_0003;
  endtask

  // Latency counts the accept edge as edge 1; bounded at 100.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (o_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_result();
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
  endtask

  task automatic watch_no_valid(input string name);
    bit seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (o_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errs++;
      $display("FAIL %s: o_valid seen=%0b want 0", name, seen);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (o_ready !== 1'b1) begin
      errs++;
      $display("FAIL rst_ready: got %b want 1", o_ready);
    end
    checks++;
    if (o_valid !== 1'b0) begin
      errs++;
      $display("FAIL rst_valid: got %b want 0", o_valid);
    end
    checks++;
    if (data !== 32'h0) begin
      errs++;
      $display("FAIL rst_data: got %h want 0", data);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_div_basic();
    int lat;
    checks++;
    if (o_ready !== 1'b1) begin
      errs++;
      $display("FAIL basic_ready: got %b want 1", o_ready);
    end
    issue(2'b00, 32'd100, 32'd7);
    wait_valid(lat);
    checks++;
    if (lat != 33) begin
      errs++;
      $display("FAIL basic_lat: got %0d want 33", lat);
    end
    checks++;
    if (data !== 32'h0000_000E) begin
      errs++;
      $display("FAIL basic_data: got %h want 0000000e", data);
    end
    release_result();
  endtask

  task automatic test_signed();
    logic [1:0]  ops [4] = '{2'b10, 2'b00, 2'b10, 2'b01};
    logic [31:0] as  [4] = '{32'hFFFF_FF9C, 32'hFFFF_FF9C,
                             32'd100, 32'hFFFF_FFFF};
    logic [31:0] bs  [4] = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'd2};
    logic [31:0] exp [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFF2,
                             32'h0000_0002, 32'h7FFF_FFFF};
    int lat;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_valid(lat);
      checks++;
      if (data !== exp[i] || lat != 33) begin
        errs++;
        $display("FAIL signed_%0d: got %h lat %0d want %h lat 33",
                 i, data, lat, exp[i]);
      end
      release_result();
    end
  endtask

  task automatic test_div_zero();
    logic [1:0]  ops [3] = '{2'b00, 2'b11, 2'b10};
    logic [31:0] as  [3] = '{32'd5, 32'd5, 32'hFFFF_FFFB};
    logic [31:0] exp [3] = '{32'hFFFF_FFFF, 32'h0000_0005,
                             32'hFFFF_FFFB};
    int lat;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], as[i], 32'd0);
      wait_valid(lat);
      checks++;
      if (lat != SPEC_LAT) begin
        errs++;
        $display("FAIL dz_lat_%0d: got %0d want %0d",
                 i, lat, SPEC_LAT);
      end
      checks++;
      if (data !== exp[i]) begin
        errs++;
        $display("FAIL dz_data_%0d: got %h want %h",
                 i, data, exp[i]);
      end
      release_result();
    end
  endtask

  task automatic test_overflow();
    int lat;
    issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_valid(lat);
    checks++;
    if (data !== 32'h8000_0000 || lat != SPEC_LAT) begin
      errs++;
      $display("FAIL ovf_div: got %h lat %0d want 80000000 lat %0d",
               data, lat, SPEC_LAT);
    end
    release_result();
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_valid(lat);
    checks++;
    if (data !== 32'h0 || lat != SPEC_LAT) begin
      errs++;
      $display("FAIL ovf_rem: got %h lat %0d want 0 lat %0d",
               data, lat, SPEC_LAT);
    end
    release_result();
  endtask

  task automatic test_backpressure();
    int lat;
    issue(2'b01, 32'd20, 32'd3);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (o_valid !== 1'b1 || data !== 32'd6 || o_ready !== 1'b0) begin
        errs++;
        $display("FAIL bp_hold_%0d: got v=%b d=%h r=%b want 1 6 0",
                 i, o_valid, data, o_ready);
      end
      @(posedge clk); #1;
    end
    release_result();
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      errs++;
      $display("FAIL bp_release: got r=%b v=%b want 1 0",
               o_ready, o_valid);
    end
  endtask

  task automatic test_flush();
    issue(2'b00, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      errs++;
      $display("FAIL flush_calc: got r=%b v=%b want 1 0",
               o_ready, o_valid);
    end
    watch_no_valid("flush_calc_quiet");
    i_valid = 1'b1;
    flush   = 1'b1;
    op_a    = 32'd100;
    op_b    = 32'd7;
    div_op  = 2'b00;
    @(posedge clk); #1;
    i_valid = 1'b0;
    flush   = 1'b0;
    checks++;
    if (o_ready !== 1'b1) begin
      errs++;
      $display("FAIL flush_idle: got r=%b want 1", o_ready);
    end
    watch_no_valid("flush_idle_quiet");
  endtask

  task automatic test_reset_mid();
    int lat;
    issue(2'b00, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (o_ready !== 1'b1 || data !== 32'h0) begin
      errs++;
      $display("FAIL rst_calc: got r=%b d=%h want 1 0", o_ready, data);
    end
    watch_no_valid("rst_calc_quiet");
    issue(2'b01, 32'd9, 32'd2);
    wait_valid(lat);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (o_valid !== 1'b0 || data !== 32'h0) begin
      errs++;
      $display("FAIL rst_done: got v=%b d=%h want 0 0", o_valid, data);
    end
    watch_no_valid("rst_done_quiet");
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(2'b00, 32'd100, 32'd7);
    wait_valid(lat);
    i_valid = 1'b1;
    div_op  = 2'b10;
    op_a    = 32'hFFFF_FF9C;
    op_b    = 32'd7;
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      errs++;
      $display("FAIL b2b_idle: got r=%b v=%b want 1 0",
               o_ready, o_valid);
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
    op_a    = 32'h1234_5678;
    wait_valid(lat);
    checks++;
    if (data !== 32'hFFFF_FFFE || lat != 33) begin
      errs++;
      $display("FAIL b2b_second: got %h lat %0d want fffffffe lat 33",
               data, lat);
    end
    release_result();
  endtask

  initial begin
    rst_n   = 1'b0;
    i_valid = 1'b0;
    op_a    = '0;
    op_b    = '0;
    div_op  = 2'b00;
    flush   = 1'b0;
    i_ready = 1'b0;
    test_reset();
    test_div_basic();
    test_signed();
    test_div_zero();
    test_overflow();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
